// File: rtl/regfile_write_arbiter.sv
// Two-requester (ALU / load) arbiter for the register file write port, with age/round-robin ordering.
// Optional same-cycle bypass of the holding buffers: define REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     SubClk,
  input  logic                     ResetN,
  input  logic                     AluValid,
  output logic                     AluReady,
  input  logic [ADDR_WIDTH-1:0]    AluReg,
  input  logic [DATA_WIDTH-1:0]    AluData,
  input  logic                     MemValid,
  output logic                     MemReady,
  input  logic [ADDR_WIDTH-1:0]    MemReg,
  input  logic [DATA_WIDTH-1:0]    MemData,
  output logic                     RegWrite,
  output logic [ADDR_WIDTH-1:0]    WriteRegister,
  output logic [DATA_WIDTH-1:0]    WriteData,
  output logic [2**ADDR_WIDTH-1:0] PendingMask
);

  logic                  alu_full_q, alu_full_d;
  logic                  mem_full_q, mem_full_d;
  logic [ADDR_WIDTH-1:0] alu_reg_q, mem_reg_q;
  logic [DATA_WIDTH-1:0] alu_data_q, mem_data_q;
  logic                  mem_older_q, mem_older_d;
  logic                  tie_q, tie_d;
  logic                  rr_mem_q, rr_mem_d;
  logic                  regwrite_q, regwrite_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic alu_acc, mem_acc, alu_load, mem_load, alu_byp, mem_byp, issue_alu, issue_mem;

  always_comb begin
    alu_acc = AluValid && !alu_full_q;
    mem_acc = MemValid && !mem_full_q;
    alu_byp = 1'b0;
    mem_byp = 1'b0;
`ifdef REGFILE_ARB_BYPASS_EN
    alu_byp = alu_acc && (AluReg != '0) && !mem_full_q && !mem_acc;
    mem_byp = mem_acc && (MemReg != '0) && !alu_full_q && !alu_acc;
`endif
    // Register-0 writes finish the handshake but are never buffered.
    alu_load = alu_acc && (AluReg != '0) && !alu_byp;
    mem_load = mem_acc && (MemReg != '0) && !mem_byp;

    issue_alu = 1'b0;
    issue_mem = 1'b0;
    if (alu_full_q && mem_full_q) begin
      issue_mem = tie_q ? rr_mem_q : mem_older_q;
      issue_alu = !issue_mem;
    end else begin
      issue_alu = alu_full_q;
      issue_mem = mem_full_q;
    end

    alu_full_d = (alu_full_q && !issue_alu) || alu_load;
    mem_full_d = (mem_full_q && !issue_mem) || mem_load;

    tie_d       = tie_q;
    mem_older_d = mem_older_q;
    rr_mem_d    = rr_mem_q;
    if (alu_full_q && mem_full_q && tie_q) rr_mem_d = !rr_mem_q;
    if (alu_load && mem_load) begin
      tie_d = 1'b1;
    end else if (alu_load) begin
      tie_d       = 1'b0;
      mem_older_d = 1'b1;
    end else if (mem_load) begin
      tie_d       = 1'b0;
      mem_older_d = 1'b0;
    end

    regwrite_d = issue_alu || issue_mem || alu_byp || mem_byp;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (issue_alu) begin
      wreg_d  = alu_reg_q;
      wdata_d = alu_data_q;
    end else if (issue_mem) begin
      wreg_d  = mem_reg_q;
      wdata_d = mem_data_q;
    end else if (alu_byp) begin
      wreg_d  = AluReg;
      wdata_d = AluData;
    end else if (mem_byp) begin
      wreg_d  = MemReg;
      wdata_d = MemData;
    end
  end

  always_ff @(posedge SubClk) begin
    if (!ResetN) begin
      alu_full_q  <= 1'b0;
      mem_full_q  <= 1'b0;
      mem_older_q <= 1'b0;
      tie_q       <= 1'b0;
      rr_mem_q    <= 1'b0;
      regwrite_q  <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
    end else begin
      alu_full_q  <= alu_full_d;
      mem_full_q  <= mem_full_d;
      mem_older_q <= mem_older_d;
      tie_q       <= tie_d;
      rr_mem_q    <= rr_mem_d;
      regwrite_q  <= regwrite_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
    end
  end

  // Buffer payload is qualified by the Full flags, so it needs no reset.
  always_ff @(posedge SubClk) begin
    if (alu_load) begin
      alu_reg_q  <= AluReg;
      alu_data_q <= AluData;
    end
    if (mem_load) begin
      mem_reg_q  <= MemReg;
      mem_data_q <= MemData;
    end
  end

  always_comb begin
    PendingMask = '0;
    if (alu_full_q) PendingMask[alu_reg_q] = 1'b1;
    if (mem_full_q) PendingMask[mem_reg_q] = 1'b1;
    PendingMask[0] = 1'b0;
  end

  assign AluReady      = !alu_full_q;
  assign MemReady      = !mem_full_q;
  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter: an ordered list of accepted writes
// models buffer occupancy; the monitor checks handshakes, mask and the retired write stream.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          SubClk = 1'b0;
  logic          ResetN = 1'b0;
  logic          AluValid = 1'b0, MemValid = 1'b0;
  logic          AluReady, MemReady;
  logic [AW-1:0] AluReg = '0, MemReg = '0;
  logic [DW-1:0] AluData = '0, MemData = '0;
  logic          RegWrite;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic [2**AW-1:0] PendingMask;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .SubClk(SubClk), .ResetN(ResetN),
    .AluValid(AluValid), .AluReady(AluReady), .AluReg(AluReg), .AluData(AluData),
    .MemValid(MemValid), .MemReady(MemReady), .MemReg(MemReg), .MemData(MemData),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .PendingMask(PendingMask)
  );

  always #5 SubClk = ~SubClk;

  typedef struct packed {
    logic          side;   // 0 = ALU, 1 = load
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  // Model state (written only by the model process)
  ent_t          pend[$];
  ent_t          expq[$];
  int            exp_base = 0;
  bit            m_init = 1'b0;
  bit            m_rw = 1'b0;
  logic [AW-1:0] m_lreg = '0;
  logic [DW-1:0] m_ldata = '0;
  bit            tie_alu_first = 1'b1;
  bit            a_hs, m_hs, a_nz, m_nz, pre_empty;
  ent_t          ae, me, hd;

  // Monitor state
  int cmp_cnt = 0;
  int fail_cnt = 0;
  int rd_idx = 0;
  ent_t ex;

  function automatic bit busy(input bit s);
    foreach (pend[i]) if (pend[i].side == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2**AW-1:0] mask_model();
    logic [2**AW-1:0] m = '0;
    foreach (pend[i]) m[pend[i].r] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    cmp_cnt++;
    if (act !== req) begin
      fail_cnt++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, req, $time);
    end
  endtask

  // Reference model: accepted writes retire strictly in acceptance order, one per edge;
  // same-edge acceptances alternate which side goes first, starting with the ALU.
  always @(posedge SubClk) begin
    if (!ResetN) begin
      pend.delete();
      exp_base      = expq.size();
      m_rw          = 1'b0;
      m_lreg        = '0;
      m_ldata       = '0;
      tie_alu_first = 1'b1;
      m_init        = 1'b1;
    end else if (m_init) begin
      a_hs      = AluValid && !busy(1'b0);
      m_hs      = MemValid && !busy(1'b1);
      a_nz      = a_hs && (AluReg != '0);
      m_nz      = m_hs && (MemReg != '0);
      pre_empty = (pend.size() == 0);
      ae        = '{side: 1'b0, r: AluReg, d: AluData};
      me        = '{side: 1'b1, r: MemReg, d: MemData};
      m_rw      = 1'b0;
      if (!pre_empty) begin
        hd      = pend.pop_front();
        m_rw    = 1'b1;
        m_lreg  = hd.r;
        m_ldata = hd.d;
      end
`ifdef REGFILE_ARB_BYPASS_EN
      if (a_nz && pre_empty && !m_hs) begin
        expq.push_back(ae);
        m_rw = 1'b1; m_lreg = ae.r; m_ldata = ae.d; a_nz = 1'b0;
      end
      if (m_nz && pre_empty && !a_hs) begin
        expq.push_back(me);
        m_rw = 1'b1; m_lreg = me.r; m_ldata = me.d; m_nz = 1'b0;
      end
`endif
      if (a_nz && m_nz) begin
        if (tie_alu_first) begin
          pend.push_back(ae); pend.push_back(me); expq.push_back(ae); expq.push_back(me);
        end else begin
          pend.push_back(me); pend.push_back(ae); expq.push_back(me); expq.push_back(ae);
        end
        tie_alu_first = !tie_alu_first;
      end else if (a_nz) begin
        pend.push_back(ae); expq.push_back(ae);
      end else if (m_nz) begin
        pend.push_back(me); expq.push_back(me);
      end
    end
  end

  // Monitor: samples on the falling edge, retires scoreboard entries as the DUT writes.
  always @(negedge SubClk) begin
    if (m_init) begin
      if (rd_idx < exp_base) rd_idx = exp_base;
      chk("alu_ready", 64'(AluReady), 64'(!busy(1'b0)));
      chk("mem_ready", 64'(MemReady), 64'(!busy(1'b1)));
      chk("pending_mask", 64'(PendingMask), 64'(mask_model()));
      chk("regwrite", 64'(RegWrite), 64'(m_rw));
      if (RegWrite === 1'b1) begin
        if (rd_idx >= expq.size()) begin
          cmp_cnt++;
          fail_cnt++;
          $display("FAIL unexpected_write actual=reg%0d required=none t=%0t", WriteRegister, $time);
        end else begin
          ex = expq[rd_idx];
          rd_idx++;
          chk("write_reg", 64'(WriteRegister), 64'(ex.r));
          chk("write_data", 64'(WriteData), 64'(ex.d));
        end
      end else begin
        chk("hold_reg", 64'(WriteRegister), 64'(m_lreg));
        chk("hold_data", 64'(WriteData), 64'(m_ldata));
      end
    end
  end

  task automatic drive(input bit rn, input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input bit mv, input logic [AW-1:0] mr, input logic [DW-1:0] md);
    @(negedge SubClk);
    ResetN = rn;
    AluValid = av; AluReg = ar; AluData = ad;
    MemValid = mv; MemReg = mr; MemData = md;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    ResetN = 1'b0; AluValid = 1'b1; MemValid = 1'b1;
    AluReg = 5'd9; MemReg = 5'd10; AluData = 32'h11; MemData = 32'h22;
    repeat (2) @(negedge SubClk);
    idle(4);
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    idle(4);
    drive(1'b1, 1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
    idle(4);
    drive(1'b1, 1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
    idle(4);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 32'd9);
    drive(1'b1, 1'b1, 5'd4, 32'd8, 1'b0, '0, '0);
    idle(4);
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0);
    idle(3);
    drive(1'b1, 1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), $urandom);
    end
    idle(6);
    chk("drain", 64'(rd_idx), 64'(expq.size()));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: the ALU result path (Alu) and the memory load path (Mem). Each requester has a one-entry holding buffer and a valid/ready handshake. The arbiter issues at most one write per cycle on registered RegWrite/WriteRegister/WriteData outputs, which drive the register file write port directly. It also exports a pending-write mask so decode can stall on registers with writes still in flight.

## Interface
Parameters:
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register index width; mask width is 2**ADDR_WIDTH

Ports:
- SubClk  in  1  clock, all state updates on rising edge
- ResetN  in  1  reset, synchronous, active-low
- AluValid  in  1  ALU write request
- AluReady  out  1  ALU buffer can accept
- AluReg  in  ADDR_WIDTH  ALU destination register
- AluData  in  DATA_WIDTH  ALU write data
- MemValid  in  1  load write request
- MemReady  out  1  load buffer can accept
- MemReg  in  ADDR_WIDTH  load destination register
- MemData  in  DATA_WIDTH  load write data
- RegWrite  out  1  write strobe to the register file, registered
- WriteRegister  out  ADDR_WIDTH  write index, registered
- WriteData  out  DATA_WIDTH  write data, registered
- PendingMask  out  2**ADDR_WIDTH  bit r set while any buffer holds a write to register r

## Operation
Buffers and handshake:
- Per requester: Full flag, register index, data.
- Ready = !Full. The transfer happens on a rising edge with Valid && Ready.
- Valid may be held high without a transfer. Data is sampled only at transfer.
- Writes to register 0 complete the handshake and are discarded. They never set Full and never assert RegWrite.

Arbitration, evaluated each cycle over the Full buffers:
- One buffer Full: it issues.
- Both Full, different acceptance cycles: the older one issues first. An Age bit records which buffer was filled first.
- Both Full, same acceptance cycle: the round-robin pointer decides. The pointer resets to Alu and flips to the loser after each tie it resolves.
- Issuing a buffer loads the outputs and clears Full on the same edge. That buffer can accept a new request no earlier than the following edge.
- No buffer Full: RegWrite goes low next cycle. WriteRegister and WriteData hold their last values.

Other rules:
- Same-register writes from both requesters always retire in acceptance order. Same-cycle acceptance uses pointer order.
- PendingMask is combinational from Full and the buffer indices. Bit 0 is always 0.

Reset (ResetN low at an edge):
- Both buffers empty, pointer = Alu, Age cleared.
- RegWrite = 0, WriteRegister = 0, WriteData = 0, PendingMask = 0, AluReady = MemReady = 1.
- Reset mid-operation drops buffered writes silently. No RegWrite is issued for them.

## Timing
- Latency without bypass: a request accepted at edge N, uncontested, gives RegWrite high in the cycle after edge N+1.
- Throughput: one write per cycle sustained with both requesters active.
- Throughput from one requester alone: one write per 2 cycles, since the buffer refills only after it drains.
- Simultaneous acceptance at edge N: the first write is visible after N+1, the second after N+2.
- Ready is low for exactly the cycles in which Full is set.

## Configuration
- REGFILE_ARB_BYPASS_EN defined:
  - An accepted request whose own buffer is empty, with the other buffer also empty and no simultaneous acceptance on the other side, skips the buffer.
  - It loads the outputs at the acceptance edge N, so RegWrite is high in the cycle after N. Latency is 1.
  - Bypassed writes never appear in PendingMask.
  - A single requester then sustains one write per cycle.
- Undefined: every non-zero write passes through its buffer, with the 2-cycle latency above.

## Test plan
- Reset: ResetN low for 2 edges with both Valids high -> RegWrite=0, PendingMask=0, both Ready=1, no write after release until a new transfer.
- Single ALU write: AluReg=5, AluData=32'hDEADBEEF at edge N -> PendingMask[5]=1 after N; RegWrite=1, WriteRegister=5, WriteData=32'hDEADBEEF after N+1 (after N with REGFILE_ARB_BYPASS_EN, PendingMask[5] never set).
- Tie, same register: Alu(7, 1) and Mem(7, 2) accepted at the same edge -> write 7<-1 then 7<-2 on consecutive cycles. Repeating the tie -> Mem first (pointer flipped).
- Age order: Mem(3, 9) at N, Alu(4, 8) at N+1 while Mem is still buffered -> register 3 written before register 4.
- Register 0: AluReg=0, AluData=32'hFFFF at N -> handshake completes, AluReady stays 1, RegWrite never asserts, PendingMask stays 0.
- Reset mid-operation: both buffers Full, ResetN low one edge -> RegWrite=0 and PendingMask=0 after that edge, no buffered write ever issued.
